// File: rtl/psum_accum_quant.sv
// -----------------------------------------------------------------------------
// psum_accum_quant
//
// Purpose:
//   Accumulates NUM_ROWS-wide partial-sum columns from the dense cores across
//   input-channel passes in an internal column buffer. On the last pass of a
//   column, the accumulated rows are shifted, rounded and saturated to
//   OUTPUT_BW and written one row per cycle to OUT_MEM port A.
//
// Configuration macro:
//   PSUM_ACC_RELU_EN - when defined, negative values are clamped to zero after
//                      the shift, before saturation.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           pulse in IDLE: latch shift_n / IMG_H / IMG_W, go to ACCEPT
//   shift_n         right-shift amount applied during quantization
//   IMG_H, IMG_W    valid rows per column / output width (address generation)
//   busy            high whenever the FSM is not IDLE
//   done            one-cycle pulse after the final column has drained
//   err_col         sticky flag: a beat arrived with in_col >= COLS_MAX
//   in_valid/ready  psum beat handshake
//   in_first        first pass: overwrite instead of accumulate
//   in_last         last pass: quantize and drain instead of storing
//   in_final        with in_last: last column of the tile
//   in_col, in_oc   output column and local output channel of the beat
//   psum_rows       row r at [r*PSUM_BW +: PSUM_BW]
//   out_mem_*       OUT_MEM port A write interface
// -----------------------------------------------------------------------------
module psum_accum_quant #(
    parameter int NUM_ROWS  = 32,
    parameter int PSUM_BW   = 32,
    parameter int OUTPUT_BW = 8,
    parameter int COLS_MAX  = 32,
    parameter int OC_AW     = 5,
    parameter int ADDR_OUT  = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [3:0]                    shift_n,
    input  logic [5:0]                    IMG_H,
    input  logic [5:0]                    IMG_W,
    output logic                          busy,
    output logic                          done,
    output logic                          err_col,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic                          in_final,
    input  logic [$clog2(COLS_MAX)-1:0]   in_col,
    input  logic [OC_AW-1:0]              in_oc,
    input  logic [NUM_ROWS*PSUM_BW-1:0]   psum_rows,
    output logic                          out_mem_ena,
    output logic                          out_mem_wea,
    output logic [ADDR_OUT-1:0]           out_mem_addra,
    output logic [OUTPUT_BW-1:0]          out_mem_dina
);

    localparam int COL_AW = $clog2(COLS_MAX);
    localparam int ROW_AW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    // Saturation bounds, held one bit wider than the accumulator so the
    // rounding add can never wrap before the clamp.
    localparam logic signed [PSUM_BW:0] Q_MAX = (PSUM_BW+1)'((1 << (OUTPUT_BW-1)) - 1);
    localparam logic signed [PSUM_BW:0] Q_MIN = ~Q_MAX;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic                 done_d;

    // Configuration latched on start
    logic [3:0]           shift_q;
    logic [5:0]           img_h_q;
    logic [5:0]           img_w_q;

    // Context of the column currently draining
    logic [COL_AW-1:0]    col_q;
    logic [OC_AW-1:0]     oc_q;
    logic                 final_q;
    logic [ROW_AW-1:0]    row_q;

    logic                 done_q;
    logic                 err_col_q;

    logic [PSUM_BW-1:0]   acc_buf  [COLS_MAX][NUM_ROWS];
    logic [PSUM_BW-1:0]   drain_vec[NUM_ROWS];
    logic [PSUM_BW-1:0]   sum_vec  [NUM_ROWS];

    logic                 accept;
    logic                 col_ok;
    logic [COL_AW-1:0]    col_idx;
    logic                 last_row;
    logic                 drain_we;
    logic [ADDR_OUT-1:0]  drain_addr;

    // -------------------------------------------------------------------------
    // Quantizer: round-half-up shift, optional ReLU, signed saturation.
    // -------------------------------------------------------------------------
    function automatic logic [OUTPUT_BW-1:0] quantize(
        input logic [PSUM_BW-1:0] s,
        input logic [3:0]         sh
    );
        logic signed [PSUM_BW:0] v;
        logic [OUTPUT_BW-1:0]    q;
        v = {s[PSUM_BW-1], s};
        if (sh != 4'd0)
            v = v + ((PSUM_BW+1)'(1) << (sh - 4'd1));
        v = v >>> sh;
`ifdef PSUM_ACC_RELU_EN
        if (v < 0)
            v = '0;
`endif
        if (v > Q_MAX)
            q = Q_MAX[OUTPUT_BW-1:0];
        else if (v < Q_MIN)
            q = Q_MIN[OUTPUT_BW-1:0];
        else
            q = v[OUTPUT_BW-1:0];
        return q;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake and beat classification
    // -------------------------------------------------------------------------
    assign in_ready = (state_q == ST_ACCEPT);
    assign accept   = in_valid && in_ready;
    assign col_ok   = 32'(in_col) < 32'(COLS_MAX);
    // Out-of-range beats are dropped; steer their index to a legal entry so
    // the buffer read never goes out of bounds.
    assign col_idx  = col_ok ? in_col : '0;

    // -------------------------------------------------------------------------
    // Accumulate: overwrite on the first pass, add (wrapping) otherwise.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (in_first)
                sum_vec[r] = psum_rows[r*PSUM_BW +: PSUM_BW];
            else
                sum_vec[r] = acc_buf[col_idx][r] + psum_rows[r*PSUM_BW +: PSUM_BW];
        end
    end

    // NOTE: the column buffer and drain vector are pure datapath storage and
    // are deliberately left out of reset; every entry is written by a first
    // pass before it is read, and a reset tree here would be huge.
    always_ff @(posedge clk) begin
        if (!reset && accept && col_ok) begin
            if (in_last) begin
                for (int r = 0; r < NUM_ROWS; r++)
                    drain_vec[r] <= sum_vec[r];
            end else begin
                for (int r = 0; r < NUM_ROWS; r++)
                    acc_buf[col_idx][r] <= sum_vec[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Drain row sequencing. The row cap at NUM_ROWS-1 also stops a bogus
    // IMG_H of 0 or > NUM_ROWS from draining forever.
    // -------------------------------------------------------------------------
    assign last_row = (32'(row_q) + 32'd1 >= 32'(img_h_q)) ||
                      (32'(row_q) == 32'(NUM_ROWS - 1));

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start)
                    state_d = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                if (accept && col_ok && in_last)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (last_row) begin
                    state_d = final_q ? ST_IDLE : ST_ACCEPT;
                    done_d  = final_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            err_col_q <= 1'b0;
            shift_q   <= '0;
            img_h_q   <= '0;
            img_w_q   <= '0;
            col_q     <= '0;
            oc_q      <= '0;
            final_q   <= 1'b0;
            row_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;

            if (state_q == ST_IDLE && start) begin
                shift_q <= shift_n;
                img_h_q <= IMG_H;
                img_w_q <= IMG_W;
            end

            if (accept && !col_ok)
                err_col_q <= 1'b1;

            if (accept && col_ok && in_last) begin
                col_q   <= in_col;
                oc_q    <= in_oc;
                final_q <= in_final;
                row_q   <= '0;
            end else if (state_q == ST_DRAIN) begin
                row_q   <= row_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // OUT_MEM write port: one row per DRAIN cycle, address wraps to ADDR_OUT.
    // -------------------------------------------------------------------------
    assign drain_we   = (state_q == ST_DRAIN);
    assign drain_addr = (ADDR_OUT'(oc_q) * ADDR_OUT'(img_h_q) + ADDR_OUT'(row_q))
                        * ADDR_OUT'(img_w_q) + ADDR_OUT'(col_q);

    assign out_mem_ena   = drain_we;
    assign out_mem_wea   = drain_we;
    assign out_mem_addra = drain_we ? drain_addr : '0;
    assign out_mem_dina  = drain_we ? quantize(drain_vec[row_q], shift_q) : '0;

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign err_col = err_col_q;

endmodule

// File: tb/tb_psum_accum_quant.sv
// -----------------------------------------------------------------------------
// tb_psum_accum_quant
//
// Directed self-checking bench for psum_accum_quant. COLS_MAX is set to 40 so
// a 6-bit in_col can carry the out-of-range index 40. Expected write data is
// hand-computed; PSUM_ACC_RELU_EN selects the clamped expectations.
// -----------------------------------------------------------------------------
module tb_psum_accum_quant;

    localparam int NUM_ROWS  = 8;
    localparam int PSUM_BW   = 32;
    localparam int OUTPUT_BW = 8;
    localparam int COLS_MAX  = 40;
    localparam int OC_AW     = 5;
    localparam int ADDR_OUT  = 15;

    logic                        clk;
    logic                        reset;
    logic                        start;
    logic [3:0]                  shift_n;
    logic [5:0]                  IMG_H;
    logic [5:0]                  IMG_W;
    logic                        busy;
    logic                        done;
    logic                        err_col;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_first;
    logic                        in_last;
    logic                        in_final;
    logic [5:0]                  in_col;
    logic [OC_AW-1:0]            in_oc;
    logic [NUM_ROWS*PSUM_BW-1:0] psum_rows;
    logic                        out_mem_ena;
    logic                        out_mem_wea;
    logic [ADDR_OUT-1:0]         out_mem_addra;
    logic [OUTPUT_BW-1:0]        out_mem_dina;

    int n_checks = 0;
    int n_errors = 0;

    psum_accum_quant #(
        .NUM_ROWS (NUM_ROWS),
        .PSUM_BW  (PSUM_BW),
        .OUTPUT_BW(OUTPUT_BW),
        .COLS_MAX (COLS_MAX),
        .OC_AW    (OC_AW),
        .ADDR_OUT (ADDR_OUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .shift_n      (shift_n),
        .IMG_H        (IMG_H),
        .IMG_W        (IMG_W),
        .busy         (busy),
        .done         (done),
        .err_col      (err_col),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_first     (in_first),
        .in_last      (in_last),
        .in_final     (in_final),
        .in_col       (in_col),
        .in_oc        (in_oc),
        .psum_rows    (psum_rows),
        .out_mem_ena  (out_mem_ena),
        .out_mem_wea  (out_mem_wea),
        .out_mem_addra(out_mem_addra),
        .out_mem_dina (out_mem_dina)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Rows 0..3 get individual values; rows 4..7 carry filler that must never
    // reach OUT_MEM because IMG_H stays at or below 4.
    task automatic set_psum(input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3);
        psum_rows[0*PSUM_BW +: PSUM_BW] = v0;
        psum_rows[1*PSUM_BW +: PSUM_BW] = v1;
        psum_rows[2*PSUM_BW +: PSUM_BW] = v2;
        psum_rows[3*PSUM_BW +: PSUM_BW] = v3;
        for (int r = 4; r < NUM_ROWS; r++)
            psum_rows[r*PSUM_BW +: PSUM_BW] = 32'd77;
    endtask

    task automatic do_start(input logic [3:0] sh, input logic [5:0] h, input logic [5:0] w);
        @(negedge clk);
        shift_n = sh;
        IMG_H   = h;
        IMG_W   = w;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one beat for exactly one accepting edge; returns just after it.
    task automatic drive_beat(input logic f, input logic l, input logic fin,
                              input logic [5:0] col, input logic [OC_AW-1:0] oc);
        @(negedge clk);
        check("ready before beat", in_ready, 1);
        in_first = f;
        in_last  = l;
        in_final = fin;
        in_col   = col;
        in_oc    = oc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Checks rows 0..h-1 on cycles t+1..t+h, then the state at t+h+1.
    // exp_d holds row r's expected byte at [r*8 +: 8]. start is dropped after
    // row 1 so a pulse raised during the drain spans a DRAIN-state edge.
    task automatic expect_drain(input string name, input int h,
                                input logic [ADDR_OUT-1:0] base, input logic [ADDR_OUT-1:0] stride,
                                input logic [31:0] exp_d, input bit fin);
        for (int r = 0; r < h; r++) begin
            @(negedge clk);
            check($sformatf("%s ena r%0d", name, r), out_mem_ena, 1);
            check($sformatf("%s wea r%0d", name, r), out_mem_wea, 1);
            check($sformatf("%s addr r%0d", name, r), out_mem_addra, base + ADDR_OUT'(r) * stride);
            check($sformatf("%s data r%0d", name, r), out_mem_dina, exp_d[r*8 +: 8]);
            if (r == 1)
                start = 1'b0;
        end
        @(negedge clk);
        check($sformatf("%s ena after", name), out_mem_ena, 0);
        if (fin) begin
            check($sformatf("%s done", name), done, 1);
            check($sformatf("%s busy after", name), busy, 0);
            check($sformatf("%s ready after", name), in_ready, 0);
            @(negedge clk);
            check($sformatf("%s done pulse", name), done, 0);
        end else begin
            check($sformatf("%s ready back", name), in_ready, 1);
            check($sformatf("%s no done", name), done, 0);
        end
    endtask

    logic [31:0] exp_sat_neg;
    logic [31:0] exp_round;

    initial begin
`ifdef PSUM_ACC_RELU_EN
        exp_sat_neg = 32'h00000000;
        exp_round   = 32'h01000200;
`else
        exp_sat_neg = 32'h80808080;
        exp_round   = 32'h01FE02FF;
`endif
        reset    = 1'b1;
        start    = 1'b0;
        shift_n  = '0;
        IMG_H    = '0;
        IMG_W    = '0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        in_final = 1'b0;
        in_col   = '0;
        in_oc    = '0;
        set_psum(0, 0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", in_ready, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err_col", err_col, 0);
        check("rst ena", out_mem_ena, 0);
        check("rst wea", out_mem_wea, 0);
        check("rst addra", out_mem_addra, 0);
        check("rst dina", out_mem_dina, 0);
        reset = 1'b0;

        // Session A: shift 0, H=4, W=4; config pins changed after latching
        do_start(4'd0, 6'd4, 6'd4);
        shift_n = 4'd7;
        IMG_H   = 6'd2;
        IMG_W   = 6'd9;
        @(negedge clk);
        check("A busy", busy, 1);

        // Pass-through: rows 1..4 to addr 1,5,9,13
        set_psum(1, 2, 3, 4);
        drive_beat(1, 1, 0, 6'd1, 5'd0);
        expect_drain("T1", 4, 15'd1, 15'd4, 32'h04030201, 0);

        // Negative saturation, oc=1 col=2: addr (4+r)*4+2
        set_psum(-32'sd1000, -32'sd1000, -32'sd1000, -32'sd1000);
        drive_beat(1, 1, 0, 6'd2, 5'd1);
        expect_drain("T3 neg", 4, 15'd18, 15'd4, exp_sat_neg, 0);

        // Positive saturation on the final column
        set_psum(5000, 5000, 5000, 5000);
        drive_beat(1, 1, 1, 6'd3, 5'd0);
        expect_drain("T3 pos", 4, 15'd3, 15'd4, 32'h7F7F7F7F, 1);

        // Session B: shift 2, H=4, W=4
        do_start(4'd2, 6'd4, 6'd4);

        // Three back-to-back passes of 100 into col 0 -> 300 -> 75
        set_psum(100, 100, 100, 100);
        drive_beat(1, 0, 0, 6'd0, 5'd0);
        drive_beat(0, 0, 0, 6'd0, 5'd0);
        drive_beat(0, 1, 0, 6'd0, 5'd0);
        expect_drain("T2", 4, 15'd0, 15'd4, 32'h4B4B4B4B, 0);

        // Rounding at col 5; a first-pass beat to col 0 is held valid through
        // the drain and must be ignored
        set_psum(-32'sd6, 6, -32'sd7, 5);
        drive_beat(1, 1, 0, 6'd5, 5'd0);
        in_first = 1'b1;
        in_last  = 1'b0;
        in_col   = 6'd0;
        set_psum(999, 999, 999, 999);
        in_valid = 1'b1;
        expect_drain("T4", 4, 15'd5, 15'd4, exp_round, 0);
        in_valid = 1'b0;

        // First+last on col 0: (7+2)>>2 = 2, buffer must stay at 200
        set_psum(7, 7, 7, 7);
        drive_beat(1, 1, 0, 6'd0, 5'd0);
        expect_drain("T4 pass", 4, 15'd0, 15'd4, 32'h02020202, 0);

        // Out-of-range column: accepted, dropped, sticky error
        set_psum(9, 9, 9, 9);
        drive_beat(1, 1, 0, 6'd40, 5'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("T5 no write c%0d", i), out_mem_ena, 0);
        end
        check("T5 err_col", err_col, 1);
        check("T5 ready", in_ready, 1);

        // Last pass on col 0: 200 + 4 = 204 -> (204+2)>>2 = 51
        set_psum(4, 4, 4, 4);
        drive_beat(0, 1, 1, 6'd0, 5'd0);
        expect_drain("T5 next", 4, 15'd0, 15'd4, 32'h33333333, 1);
        check("T5 err sticky", err_col, 1);

        // Session C: H=2, final beat; start raised during DRAIN is ignored
        do_start(4'd0, 6'd2, 6'd4);
        set_psum(1, 2, 3, 4);
        drive_beat(1, 1, 1, 6'd1, 5'd0);
        shift_n = 4'd3;
        IMG_H   = 6'd4;
        start   = 1'b1;
        expect_drain("T6", 2, 15'd1, 15'd4, 32'h00000201, 1);
        check("T6 idle busy", busy, 0);
        check("T6 idle ready", in_ready, 0);

        // Session D: reset during the first drain write aborts the rest
        do_start(4'd0, 6'd4, 6'd4);
        drive_beat(1, 1, 0, 6'd1, 5'd0);
        @(negedge clk);
        check("T6 rst row0 ena", out_mem_ena, 1);
        check("T6 rst row0 addr", out_mem_addra, 1);
        reset = 1'b1;
        @(negedge clk);
        check("T6 rst abort ena", out_mem_ena, 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("T6 rst quiet c%0d", i), out_mem_ena, 0);
        end
        check("T6 rst busy", busy, 0);
        check("T6 rst err_col", err_col, 0);
        check("T6 rst ready", in_ready, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
